ped_request_conditioner: RTL and testbench

// - Upstream front-end for the traffic controller's pedestrian_request input.
// - Turns a raw, asynchronous, bouncy push-button into a clean, held request level.
// - The request is held until the controller grants the walk phase.
// - After each crossing, enforces a cooldown so repeated presses cannot starve traffic.
// - Drives the "request registered" lamp at the crossing and keeps a saturating count of accepted presses.

---
 rtl/ped_request_conditioner.sv | 154 +++++++++++++++
 tb/tb_ped_request_conditioner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
// Front-end for the traffic controller's pedestrian_request input: synchronizes
// and debounces the raw push-button, holds an accepted request until the walk
// phase is granted, enforces a cooldown after each crossing, drives the
// "request registered" lamp and keeps a saturating count of accepted presses.
module ped_request_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 10,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button_raw,
    input  logic             pedestrian_walk,
    output logic             pedestrian_request,
    output logic             request_lamp,
    output logic             request_dropped,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned CD_W = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SERVING,
        ST_COOLDOWN
    } state_t;

    // Synchronizer and debounce state
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_btn_db;
    logic                   r_btn_db_d;
    logic                   w_press;

    // FSM and datapath state
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CD_W-1:0]        r_cd_cnt;
    logic [CD_W-1:0]        w_cd_nxt;
    logic                   w_drop_nxt;
    logic                   w_accept;
    logic                   r_request;
    logic                   r_lamp;
    logic                   r_dropped;
    logic [CNT_W-1:0]       r_press_count;

    assign w_btn_s = r_sync[SYNC_STAGES-1];
    assign w_press = r_btn_db & ~r_btn_db_d;

    // Shift the asynchronous button through the synchronizer chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], button_raw};
        end
    end

    // Debounce: flip the level after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (w_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= '0;
                r_btn_db <= ~r_btn_db;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Request FSM next-state, cooldown counter and reject decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd_cnt;
        w_drop_nxt  = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    if (pedestrian_walk) begin
                        w_drop_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (pedestrian_walk) begin
                    w_state_nxt = ST_SERVING;
                end
            end
            ST_SERVING: begin
                w_drop_nxt = w_press;
                if (!pedestrian_walk) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_cd_nxt    = CD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                w_drop_nxt = w_press;
                if (r_cd_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cd_nxt = r_cd_cnt - CD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register state, counters and glitch-free outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cd_cnt      <= '0;
            r_request     <= 1'b0;
            r_lamp        <= 1'b0;
            r_dropped     <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cd_cnt  <= w_cd_nxt;
            r_request <= (w_state_nxt == ST_PENDING);
            r_lamp    <= (w_state_nxt == ST_PENDING);
            r_dropped <= w_drop_nxt;
            if (w_accept && (r_press_count != '1)) begin
                r_press_count <= r_press_count + CNT_W'(1);
            end
        end
    end

    assign pedestrian_request = r_request;
    assign request_lamp       = r_lamp;
    assign request_dropped    = r_dropped;
    assign press_count        = r_press_count;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Testbench for ped_request_conditioner: directed scenarios with literal
// expectations plus randomized button/walk traffic, all checked every cycle
// against a behavioural model of the request conditioner.
module tb_ped_request_conditioner;

    localparam int P_SYNC = 2;
    localparam int P_DEB  = 4;
    localparam int P_COOL = 10;

    logic       clk;
    logic       rst_n;
    logic       raw;
    logic       walk;
    logic       req, lamp, drop;
    logic [7:0] cnt;
    logic       req2, lamp2, drop2;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = 0;

    ped_request_conditioner #(
        .SYNC_STAGES(P_SYNC), .DEBOUNCE_CYCLES(P_DEB),
        .COOLDOWN_CYCLES(P_COOL), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .button_raw(raw), .pedestrian_walk(walk),
        .pedestrian_request(req), .request_lamp(lamp),
        .request_dropped(drop), .press_count(cnt)
    );

    ped_request_conditioner #(
        .SYNC_STAGES(P_SYNC), .DEBOUNCE_CYCLES(P_DEB),
        .COOLDOWN_CYCLES(P_COOL), .CNT_W(2)
    ) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .button_raw(raw), .pedestrian_walk(walk),
        .pedestrian_request(req2), .request_lamp(lamp2),
        .request_dropped(drop2), .press_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    // Button delayed by the synchronizer, debounced by a sliding window of
    // synced samples, then request life-cycle tracked with flags and a
    // cooldown exit timestamp.
    bit m_valid = 0;
    bit m_sync [P_SYNC];
    bit m_win  [P_DEB];
    bit m_db, m_db_d;
    bit m_waiting, m_serving, m_cooling;
    bit m_drop;
    int m_cool_exit;
    int m_acc;
    int mcyc = 0;

    always @(posedge clk) begin
        bit press, bs, all_diff;
        if (!rst_n) begin
            for (int i = 0; i < P_SYNC; i++) m_sync[i] = 0;
            for (int i = 0; i < P_DEB; i++) m_win[i] = 0;
            m_db = 0; m_db_d = 0;
            m_waiting = 0; m_serving = 0; m_cooling = 0;
            m_drop = 0; m_acc = 0; m_cool_exit = 0;
            m_valid = 1;
        end else begin
            press  = m_db && !m_db_d;
            m_drop = 0;
            if (m_cooling) begin
                if (press) m_drop = 1;
                if (mcyc == m_cool_exit) m_cooling = 0;
            end else if (m_serving) begin
                if (press) m_drop = 1;
                if (!walk) begin
                    m_serving = 0; m_cooling = 1; m_cool_exit = mcyc + P_COOL;
                end
            end else if (m_waiting) begin
                if (walk) begin m_waiting = 0; m_serving = 1; end
            end else if (press) begin
                if (walk) m_drop = 1;
                else begin m_waiting = 1; m_acc++; end
            end
            bs = m_sync[P_SYNC-1];
            for (int i = P_DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = bs;
            all_diff = 1;
            for (int i = 0; i < P_DEB; i++) if (m_win[i] == m_db) all_diff = 0;
            m_db_d = m_db;
            if (all_diff) m_db = !m_db;
            for (int i = P_SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = raw;
        end
        mcyc++;
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Compare both DUTs against the model on every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_req",    int'(req),   int'(m_waiting));
            cmp("model_lamp",   int'(lamp),  int'(m_waiting));
            cmp("model_drop",   int'(drop),  int'(m_drop));
            cmp("model_count",  int'(cnt),   sat(m_acc, 255));
            cmp("model_req_w2", int'(req2),  int'(m_waiting));
            cmp("model_lamp_w2",int'(lamp2), int'(m_waiting));
            cmp("model_drop_w2",int'(drop2), int'(m_drop));
            cmp("model_cnt_w2", int'(cnt2),  sat(m_acc, 3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance to the negedge following relative edge n (edge 0 = first after release)
    task automatic at_edge(input int n);
        int guard = 0;
        while ((cyc - base) < n + 1 && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    task automatic release_reset;
        rst_n = 1'b1;
        base  = cyc;
    endtask

    initial begin
        rst_n = 1'b0; raw = 1'b1; walk = 1'b0;

        // Reset with button held, then release with button still held
        tick(); tick();
        cmp("rst_req", int'(req), 0);
        cmp("rst_lamp", int'(lamp), 0);
        cmp("rst_drop", int'(drop), 0);
        cmp("rst_count", int'(cnt), 0);
        release_reset();
        at_edge(5);  cmp("lat_req_e5", int'(req), 0);
        at_edge(6);  cmp("lat_req_e6", int'(req), 1);
                     cmp("lat_lamp_e6", int'(lamp), 1);
                     cmp("lat_count_e6", int'(cnt), 1);
        at_edge(9);  raw = 1'b0;
        at_edge(19); walk = 1'b1;
        at_edge(20); cmp("walk_req_e20", int'(req), 0);
                     cmp("walk_lamp_e20", int'(lamp), 0);
        at_edge(24); walk = 1'b0;                 // cooldown edges 25..35
        at_edge(25); raw = 1'b1;
        at_edge(30); raw = 1'b0;
        at_edge(31); cmp("cd_drop_e31", int'(drop), 0);
        at_edge(32); cmp("cd_drop_e32", int'(drop), 1);
                     cmp("cd_req_e32", int'(req), 0);
                     cmp("cd_count_e32", int'(cnt), 1);
        at_edge(33); cmp("cd_drop_e33", int'(drop), 0);
        at_edge(40); raw = 1'b1;
        at_edge(47); cmp("acc2_req", int'(req), 1);
                     cmp("acc2_count", int'(cnt), 2);
                     cmp("acc2_cnt_w2", int'(cnt2), 2);
        at_edge(49); raw = 1'b0;
        at_edge(54); walk = 1'b1;
        at_edge(55); cmp("walk2_req", int'(req), 0);
        at_edge(57); walk = 1'b0;                 // cooldown edges 58..68
        at_edge(61); raw = 1'b1;
        at_edge(66); raw = 1'b0;
        at_edge(67); cmp("exit_drop_e67", int'(drop), 0);
        at_edge(68); cmp("exit_drop_e68", int'(drop), 1);
                     cmp("exit_req_e68", int'(req), 0);
        at_edge(69); cmp("exit_drop_e69", int'(drop), 0);
                     cmp("exit_req_e69", int'(req), 0);
                     cmp("exit_count", int'(cnt), 2);
        at_edge(72); raw = 1'b1;
        at_edge(79); cmp("acc3_req", int'(req), 1);
                     cmp("acc3_count", int'(cnt), 3);
                     cmp("acc3_cnt_w2", int'(cnt2), 3);
        at_edge(81); raw = 1'b0;
        at_edge(87); walk = 1'b1;
        at_edge(88); cmp("walk3_req", int'(req), 0);
        at_edge(89); walk = 1'b0;                 // cooldown edges 90..100
        at_edge(94); raw = 1'b1;
        at_edge(100); cmp("idle_req_e100", int'(req), 0);
                      cmp("idle_drop_e100", int'(drop), 0);
        at_edge(101); cmp("acc4_req", int'(req), 1);
                      cmp("acc4_drop", int'(drop), 0);
                      cmp("acc4_count", int'(cnt), 4);
                      cmp("acc4_cnt_w2_sat", int'(cnt2), 3);

        // Bounce: 1,0,1,1,0 then 0 must not register a press
        rst_n = 1'b0; raw = 1'b0; walk = 1'b0;
        tick(); tick();
        raw = 1'b1;
        release_reset();
        at_edge(0);  raw = 1'b0;
        at_edge(1);  raw = 1'b1;
        at_edge(3);  raw = 1'b0;
        at_edge(15); cmp("bounce_req", int'(req), 0);
                     cmp("bounce_count", int'(cnt), 0);
                     cmp("bounce_drop", int'(drop), 0);

        // Mid-operation reset while a request is pending
        raw = 1'b1;                               // first sampled at edge 16
        at_edge(22); cmp("mid_pending_req", int'(req), 1);
        rst_n = 1'b0; raw = 1'b0;
        tick();
        cmp("mid_rst_req", int'(req), 0);
        cmp("mid_rst_lamp", int'(lamp), 0);
        cmp("mid_rst_count", int'(cnt), 0);
        release_reset();
        at_edge(15); cmp("mid_after_req", int'(req), 0);
                     cmp("mid_after_lamp", int'(lamp), 0);

        // Randomized traffic: bouncy bursts, walk toggling, rare resets
        for (int n = 0; n < 400; n++) begin
            int hold;
            hold = $urandom_range(1, 14);
            raw  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) walk = ~walk;
            if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
            for (int k = 0; k < hold; k++) begin
                tick();
                rst_n = 1'b1;
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
